// File: rtl/dds_pkg.sv
// Shared constants and types for the DDS waveform source and its lookup ROMs.
package dds_pkg;

  localparam int         LUT_ADDR_W = 8;
  localparam logic [7:0] MIDSCALE   = 8'h80;

  typedef enum logic [1:0] {
    WAVE_SAW = 2'd0,
    WAVE_TRI = 2'd1,
    WAVE_SQR = 2'd2,
    WAVE_SIN = 2'd3
  } wave_sel_t;

endpackage

// File: rtl/sine_qlut.sv
// Quarter-wave sine ROM: q[i] = round(127 * sin(pi/2 * i/64)), combinational.
module sine_qlut (
  input  logic [5:0] addr,
  output logic [6:0] q
);

  always_comb begin
    q = 7'd0;
    case (addr)
      6'd0:  q = 7'd0;    6'd1:  q = 7'd3;    6'd2:  q = 7'd6;    6'd3:  q = 7'd9;
      6'd4:  q = 7'd12;   6'd5:  q = 7'd16;   6'd6:  q = 7'd19;   6'd7:  q = 7'd22;
      6'd8:  q = 7'd25;   6'd9:  q = 7'd28;   6'd10: q = 7'd31;   6'd11: q = 7'd34;
      6'd12: q = 7'd37;   6'd13: q = 7'd40;   6'd14: q = 7'd43;   6'd15: q = 7'd46;
      6'd16: q = 7'd49;   6'd17: q = 7'd51;   6'd18: q = 7'd54;   6'd19: q = 7'd57;
      6'd20: q = 7'd60;   6'd21: q = 7'd63;   6'd22: q = 7'd65;   6'd23: q = 7'd68;
      6'd24: q = 7'd71;   6'd25: q = 7'd73;   6'd26: q = 7'd76;   6'd27: q = 7'd78;
      6'd28: q = 7'd81;   6'd29: q = 7'd83;   6'd30: q = 7'd85;   6'd31: q = 7'd88;
      6'd32: q = 7'd90;   6'd33: q = 7'd92;   6'd34: q = 7'd94;   6'd35: q = 7'd96;
      6'd36: q = 7'd98;   6'd37: q = 7'd100;  6'd38: q = 7'd102;  6'd39: q = 7'd104;
      6'd40: q = 7'd106;  6'd41: q = 7'd107;  6'd42: q = 7'd109;  6'd43: q = 7'd111;
      6'd44: q = 7'd112;  6'd45: q = 7'd113;  6'd46: q = 7'd115;  6'd47: q = 7'd116;
      6'd48: q = 7'd117;  6'd49: q = 7'd118;  6'd50: q = 7'd120;  6'd51: q = 7'd121;
      6'd52: q = 7'd122;  6'd53: q = 7'd122;  6'd54: q = 7'd123;  6'd55: q = 7'd124;
      6'd56: q = 7'd125;  6'd57: q = 7'd125;  6'd58: q = 7'd126;  6'd59: q = 7'd126;
      6'd60: q = 7'd126;  6'd61: q = 7'd127;  6'd62: q = 7'd127;  6'd63: q = 7'd127;
      default: q = 7'd0;
    endcase
  end

endmodule

// File: rtl/dds_wave_gen.sv
// DDS waveform source: phase accumulator plus saw/triangle/square/sine mapping,
// two-stage pipeline from the Sample_En tick to DA_Data/Data_Valid.
module dds_wave_gen
  import dds_pkg::*;
#(
  parameter int                 PHASE_W = 24,
  parameter logic [PHASE_W-1:0] FTW_RST = PHASE_W'(24'h010000)
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               Sample_En,
  input  logic [PHASE_W-1:0] FTW_In,
  input  logic               FTW_Load,
  input  logic [1:0]         Wave_Sel,
  output logic [7:0]         DA_Data,
  output logic               Data_Valid,
  output logic               Phase_Wrap
);

  logic [PHASE_W-1:0]    ftw_shadow;
  logic [PHASE_W-1:0]    ftw_eff;
  logic [PHASE_W-1:0]    phase_p1;
  logic                  carry_p1;
  wave_sel_t             wave_p1;
  logic                  vld_p1;
  logic [LUT_ADDR_W-1:0] lut_a;
  logic [5:0]            q_addr;
  logic [6:0]            q_val;
  logic [7:0]            data_p2;
  logic                  vld_p2;
  logic                  wrap_p2;

  function automatic logic [7:0] wave_map(input wave_sel_t w, input logic [7:0] a,
                                          input logic [6:0] q);
    case (w)
      WAVE_SAW: return a;
      WAVE_TRI: return a[7] ? ~{a[6:0], 1'b0} : {a[6:0], 1'b0};
      WAVE_SQR: return a[7] ? 8'h00 : 8'hFF;
      default:  return a[7] ? (8'd127 - {1'b0, q}) : (8'd128 + {1'b0, q});
    endcase
  endfunction

  // The shadow is copied to the active word on every tick, so the add can use
  // the post-copy value directly; a coincident load bypasses the shadow.
  assign ftw_eff = FTW_Load ? FTW_In : ftw_shadow;

  assign lut_a  = phase_p1[PHASE_W-1 -: LUT_ADDR_W];
  assign q_addr = lut_a[6] ? ~lut_a[5:0] : lut_a[5:0];

  sine_qlut u_qlut (
    .addr (q_addr),
    .q    (q_val)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ftw_shadow <= FTW_RST;
      phase_p1   <= '0;
      carry_p1   <= 1'b0;
      wave_p1    <= WAVE_SAW;
      vld_p1     <= 1'b0;
      data_p2    <= MIDSCALE;
      vld_p2     <= 1'b0;
      wrap_p2    <= 1'b0;
    end else begin
      if (FTW_Load) ftw_shadow <= FTW_In;
      // stage 1: accumulate and latch the waveform selection
      if (Sample_En) begin
        {carry_p1, phase_p1} <= {1'b0, phase_p1} + {1'b0, ftw_eff};
        wave_p1              <= wave_sel_t'(Wave_Sel);
      end
      vld_p1 <= Sample_En;
      // stage 2: map updated phase to the output sample
      if (vld_p1) data_p2 <= wave_map(wave_p1, lut_a, q_val);
      vld_p2  <= vld_p1;
      wrap_p2 <= vld_p1 & carry_p1;
    end
  end

  assign DA_Data    = data_p2;
  assign Data_Valid = vld_p2;
  assign Phase_Wrap = wrap_p2;

endmodule

// File: tb/tb_dds_wave_gen.sv
// Self-checking bench for dds_wave_gen against a phase/waveform reference model.
module tb_dds_wave_gen;

  localparam int          PW      = 24;
  localparam logic [23:0] FTW_DEF = 24'h010000;
  localparam real         PI      = 3.14159265358979;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        Sample_En = 1'b0;
  logic [23:0] FTW_In = '0;
  logic        FTW_Load = 1'b0;
  logic [1:0]  Wave_Sel = 2'd0;
  logic [7:0]  DA_Data;
  logic        Data_Valid;
  logic        Phase_Wrap;

  int     vectors = 0;
  int     miscompares = 0;
  int     qtab [64];
  longint m_phase;
  longint m_ftw;
  logic   se_q = 1'b0;

  dds_wave_gen #(.PHASE_W(PW), .FTW_RST(FTW_DEF)) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .Sample_En  (Sample_En),
    .FTW_In     (FTW_In),
    .FTW_Load   (FTW_Load),
    .Wave_Sel   (Wave_Sel),
    .DA_Data    (DA_Data),
    .Data_Valid (Data_Valid),
    .Phase_Wrap (Phase_Wrap)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) se_q <= Sample_En;
  always @(posedge CLK)
    if (RSTn) assert (!(se_q && Sample_En)) else $error("FAIL back_to_back Sample_En observed");

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [1:0] ws, input int a);
    int quad = a / 64;
    int i    = a % 64;
    case (ws)
      2'd0: return 8'(a);
      2'd1: return (a < 128) ? 8'(2 * a) : 8'(511 - 2 * a);
      2'd2: return (a < 128) ? 8'd255 : 8'd0;
      default:
        case (quad)
          0:       return 8'(128 + qtab[i]);
          1:       return 8'(128 + qtab[63 - i]);
          2:       return 8'(127 - qtab[i]);
          default: return 8'(127 - qtab[63 - i]);
        endcase
    endcase
  endfunction

  task automatic tick(input logic [1:0] ws, input bit load, input logic [23:0] fin,
                      input string tag);
    longint nxt;
    bit     exp_wrap;
    logic [7:0] exp_d;
    @(negedge CLK);
    Sample_En = 1'b1; Wave_Sel = ws; FTW_Load = load; FTW_In = fin;
    @(posedge CLK); #1;
    Sample_En = 1'b0; FTW_Load = 1'b0; Wave_Sel = 2'($urandom);
    if (load) m_ftw = longint'(fin);
    nxt      = m_phase + m_ftw;
    exp_wrap = (nxt >= (64'sd1 << PW));
    m_phase  = nxt % (64'sd1 << PW);
    exp_d    = model(ws, int'(m_phase >> (PW - 8)));
    check({tag, "_vld_early"}, 32'(Data_Valid), 32'd0);
    @(posedge CLK); #1;
    check({tag, "_vld"},  32'(Data_Valid), 32'd1);
    check({tag, "_data"}, 32'(DA_Data),    32'(exp_d));
    check({tag, "_wrap"}, 32'(Phase_Wrap), 32'(exp_wrap));
    @(posedge CLK); #1;
    check({tag, "_vld_pulse"}, 32'(Data_Valid), 32'd0);
    check({tag, "_wrap_pulse"}, 32'(Phase_Wrap), 32'd0);
  endtask

  task automatic load_between(input logic [23:0] fin);
    @(negedge CLK);
    FTW_Load = 1'b1; FTW_In = fin;
    @(posedge CLK); #1;
    FTW_Load = 1'b0;
    m_ftw = longint'(fin);
    check("load_no_vld", 32'(Data_Valid), 32'd0);
  endtask

  initial begin
    logic [7:0] held;
    for (int i = 0; i < 64; i++) qtab[i] = $rtoi($floor(127.0 * $sin(PI * i / 128.0) + 0.5));
    m_phase = 0;
    m_ftw   = longint'(FTW_DEF);

    // reset and idle
    repeat (3) @(posedge CLK);
    #1;
    check("rst_data", 32'(DA_Data), 32'h80);
    check("rst_vld",  32'(Data_Valid), 32'd0);
    @(negedge CLK); RSTn = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge CLK); #1;
      check("idle_data", 32'(DA_Data), 32'h80);
      check("idle_vld",  32'(Data_Valid), 32'd0);
      check("idle_wrap", 32'(Phase_Wrap), 32'd0);
    end

    // saw sweep over one full period
    for (int k = 0; k < 256; k++) tick(2'd0, 1'b0, 24'h0, "saw");
    check("saw_end_zero", 32'(DA_Data), 32'd0);

    // triangle then square at 16 LUT steps
    load_between(24'h100000);
    for (int k = 0; k < 16; k++) tick(2'd1, 1'b0, 24'h0, "tri");
    for (int k = 0; k < 16; k++) tick(2'd2, 1'b0, 24'h0, "sqr");
    tick(2'd1, 1'b0, 24'h0, "sel_change");

    // sine spot checks at quarter-period steps
    load_between(24'h400000);
    m_phase = 0;
    @(negedge CLK); RSTn = 1'b0; @(negedge CLK); RSTn = 1'b1;
    load_between(24'h400000);
    tick(2'd3, 1'b0, 24'h0, "sin64");  check("sin_a64",  32'(DA_Data), 32'd255);
    tick(2'd3, 1'b0, 24'h0, "sin128"); check("sin_a128", 32'(DA_Data), 32'd127);
    tick(2'd3, 1'b0, 24'h0, "sin192"); check("sin_a192", 32'(DA_Data), 32'd0);
    tick(2'd3, 1'b0, 24'h0, "sin0");   check("sin_a0",   32'(DA_Data), 32'd128);
    check("sin_wrap4", 32'(Phase_Wrap), 32'd0);

    // tuning word reload: coincident, between ticks, and zero
    load_between(24'h010000);
    tick(2'd0, 1'b0, 24'h0, "pre_load");
    tick(2'd0, 1'b1, 24'h020000, "coincident");
    check("coincident_a2", 32'(DA_Data), 32'd3);
    load_between(24'h030000);
    tick(2'd0, 1'b0, 24'h0, "between");
    check("between_a3", 32'(DA_Data), 32'd6);
    load_between(24'h000000);
    held = DA_Data;
    for (int k = 0; k < 4; k++) begin
      tick(2'd0, 1'b0, 24'h0, "ftw0");
      check("ftw0_hold", 32'(DA_Data), 32'(held));
    end

    // randomized mix of waveforms and tuning-word loads
    for (int k = 0; k < 150; k++) begin
      int r = int'($urandom_range(0, 99));
      if (r < 15) load_between(24'($urandom));
      tick(2'($urandom), (r >= 15 && r < 40), 24'($urandom), "rand");
    end

    // reset in the cycle after a tick aborts the pipeline
    @(negedge CLK);
    Sample_En = 1'b1; Wave_Sel = 2'd3;
    @(posedge CLK); #1;
    Sample_En = 1'b0;
    RSTn = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      check("midrst_vld",  32'(Data_Valid), 32'd0);
      check("midrst_data", 32'(DA_Data), 32'h80);
    end
    @(negedge CLK); RSTn = 1'b1;
    m_phase = 0;
    m_ftw   = longint'(FTW_DEF);
    @(posedge CLK); #1;
    check("postrst_vld", 32'(Data_Valid), 32'd0);
    tick(2'd0, 1'b0, 24'h0, "postrst");
    check("postrst_a1", 32'(DA_Data), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
